// File: rtl/sdram_fb_arbiter.sv
// sdram_fb_arbiter
//
// Shares the single SDRAM controller command port between the write path
// (window pixels gathered in a write FIFO) and the read path (HDMI read FIFO).
// It also sequences the triple-buffered frame store, so the display never
// reads the bank that is currently being written.
//
// Ports:
//   clk, rstn       clock; asynchronous active-low reset
//   wr_frame_start  pulse: first window pixel of a new frame
//   wr_fifo_level   words waiting in the write FIFO
//   rd_frame_start  pulse: display vsync
//   rd_fifo_level   words held in the read FIFO
//   cmd_valid/ready command handshake toward the SDRAM controller
//   cmd_we          1 = write burst, 0 = read burst
//   cmd_addr        burst start word address (bank*BANK_STRIDE + offset)
//   cmd_len         burst length, 1..BURST_LEN
//   cmd_done        pulse: the accepted burst has finished
//   wr_bank         bank being written
//   rd_bank         bank being displayed
//   frame_valid     at least one complete frame is stored
//
// Optional build macro SDRAM_ARB_STAT_EN adds the saturating counters
// stat_wr_frames, stat_rd_repeats and stat_urgent.

module sdram_fb_arbiter #(
    parameter int unsigned BURST_LEN     = 256,
    parameter int unsigned FRAME_WORDS   = 307200,
    parameter int unsigned BANK_STRIDE   = 32'h0008_0000,
    parameter int unsigned ADDR_W        = 24,
    parameter int unsigned FIFO_AW       = 10,
    parameter int unsigned RD_FIFO_DEPTH = 1024,
    parameter int unsigned RD_URGENT     = 128
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_frame_start,
    input  logic [FIFO_AW:0]  wr_fifo_level,
    input  logic              rd_frame_start,
    input  logic [FIFO_AW:0]  rd_fifo_level,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_we,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [8:0]        cmd_len,
    input  logic              cmd_done,
    output logic [1:0]        wr_bank,
    output logic [1:0]        rd_bank,
    output logic              frame_valid
`ifdef SDRAM_ARB_STAT_EN
    ,
    output logic [15:0]       stat_wr_frames,
    output logic [15:0]       stat_rd_repeats,
    output logic [15:0]       stat_urgent
`endif
);

    localparam int unsigned OFF_W = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_t;

    state_t            state_q, state_d;
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [8:0]        cmd_len_q, cmd_len_d;
    logic [1:0]        wr_bank_q, wr_bank_d;
    logic [1:0]        rd_bank_q, rd_bank_d;
    logic [1:0]        last_full_q, last_full_d;
    logic              frame_valid_q, frame_valid_d;
    logic [OFF_W-1:0]  wr_off_q, wr_off_d;
    logic [OFF_W-1:0]  rd_off_q, rd_off_d;
    logic              rd_busy_q, rd_busy_d;
    // Writer is armed by wr_frame_start and parks after a full frame.
    logic              wr_active_q, wr_active_d;
    // 1 = last completed burst was a write.
    logic              last_grant_q, last_grant_d;
    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;

    int unsigned       wlen, rlen;
    logic              wr_elig, rd_elig, rd_urgent_lvl, grant_rd;

    // Lowest-index bank that is neither the stored frame nor the displayed one.
    function automatic logic [1:0] pick_wr_bank(input logic [1:0] full, input logic [1:0] rd);
        logic [1:0] b;
        b = 2'd2;
        for (int i = 2; i >= 0; i--) begin
            if (2'(i) != full && 2'(i) != rd) b = 2'(i);
        end
        return b;
    endfunction

    function automatic logic [ADDR_W-1:0] bank_addr(input logic [1:0] bank,
                                                    input logic [OFF_W-1:0] off);
        return ADDR_W'(bank) * ADDR_W'(BANK_STRIDE) + ADDR_W'(off);
    endfunction

    always_comb begin
        state_d       = state_q;
        cmd_we_d      = cmd_we_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_len_d     = cmd_len_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        last_full_d   = last_full_q;
        frame_valid_d = frame_valid_q;
        wr_off_d      = wr_off_q;
        rd_off_d      = rd_off_q;
        rd_busy_d     = rd_busy_q;
        wr_active_d   = wr_active_q;
        last_grant_d  = last_grant_q;
        wr_pend_d     = wr_pend_q | wr_frame_start;
        rd_pend_d     = rd_pend_q | rd_frame_start;
        wlen          = 0;
        rlen          = 0;
        wr_elig       = 1'b0;
        rd_elig       = 1'b0;
        rd_urgent_lvl = 32'(rd_fifo_level) < RD_URGENT;
        grant_rd      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Completion bookkeeping precedes any start applied this cycle.
                if (wr_active_q && 32'(wr_off_q) == FRAME_WORDS) begin
                    last_full_d   = wr_bank_q;
                    frame_valid_d = 1'b1;
                    wr_off_d      = '0;
                    wr_active_d   = 1'b0;
                    wr_bank_d     = pick_wr_bank(wr_bank_q, rd_bank_q);
                end
                if (rd_busy_q && 32'(rd_off_q) == FRAME_WORDS) begin
                    rd_busy_d = 1'b0;
                end
                if (wr_pend_d) begin
                    wr_pend_d   = 1'b0;
                    wr_off_d    = '0;
                    wr_active_d = 1'b1;
                end
                if (rd_pend_d) begin
                    rd_pend_d = 1'b0;
                    if (frame_valid_d) begin
                        rd_bank_d = last_full_d;
                        rd_off_d  = '0;
                        rd_busy_d = 1'b1;
                    end
                end

                // Eligibility is judged on the bookkeeping just applied.
                if (wr_active_d) begin
                    wlen = FRAME_WORDS - 32'(wr_off_d);
                    if (wlen > BURST_LEN) wlen = BURST_LEN;
                    wr_elig = 32'(wr_fifo_level) >= wlen;
                end
                if (rd_busy_d) begin
                    rlen = FRAME_WORDS - 32'(rd_off_d);
                    if (rlen > BURST_LEN) rlen = BURST_LEN;
                    rd_elig = 32'(rd_fifo_level) + rlen <= RD_FIFO_DEPTH;
                end

                if (wr_elig && rd_elig) begin
                    grant_rd = rd_urgent_lvl || last_grant_q;
                end else begin
                    grant_rd = rd_elig;
                end

                if (wr_elig || rd_elig) begin
                    state_d = StReq;
                    if (grant_rd) begin
                        cmd_we_d   = 1'b0;
                        cmd_addr_d = bank_addr(rd_bank_d, rd_off_d);
                        cmd_len_d  = 9'(rlen);
                    end else begin
                        cmd_we_d   = 1'b1;
                        cmd_addr_d = bank_addr(wr_bank_d, wr_off_d);
                        cmd_len_d  = 9'(wlen);
                    end
                end
            end

            StReq: begin
                if (cmd_ready) state_d = StWait;
            end

            StWait: begin
                if (cmd_done) begin
                    if (cmd_we_q) wr_off_d = wr_off_q + OFF_W'(cmd_len_q);
                    else          rd_off_d = rd_off_q + OFF_W'(cmd_len_q);
                    last_grant_d = cmd_we_q;
                    state_d      = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StIdle;
            cmd_we_q      <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_len_q     <= '0;
            wr_bank_q     <= '0;
            rd_bank_q     <= '0;
            last_full_q   <= '0;
            frame_valid_q <= 1'b0;
            wr_off_q      <= '0;
            rd_off_q      <= '0;
            rd_busy_q     <= 1'b0;
            wr_active_q   <= 1'b0;
            last_grant_q  <= 1'b0;
            wr_pend_q     <= 1'b0;
            rd_pend_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_we_q      <= cmd_we_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_len_q     <= cmd_len_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            last_full_q   <= last_full_d;
            frame_valid_q <= frame_valid_d;
            wr_off_q      <= wr_off_d;
            rd_off_q      <= rd_off_d;
            rd_busy_q     <= rd_busy_d;
            wr_active_q   <= wr_active_d;
            last_grant_q  <= last_grant_d;
            wr_pend_q     <= wr_pend_d;
            rd_pend_q     <= rd_pend_d;
        end
    end

    // Decoded from the state register so reset drops the request at once.
    assign cmd_valid   = (state_q == StReq);
    assign cmd_we      = cmd_we_q;
    assign cmd_addr    = cmd_addr_q;
    assign cmd_len     = cmd_len_q;
    assign wr_bank     = wr_bank_q;
    assign rd_bank     = rd_bank_q;
    assign frame_valid = frame_valid_q;

`ifdef SDRAM_ARB_STAT_EN
    logic [15:0] stat_wr_frames_q, stat_rd_repeats_q, stat_urgent_q;
    logic        rd_shown_q;
    logic        wr_frame_evt, rd_apply_evt, rd_repeat_evt, urgent_evt;

    always_comb begin
        wr_frame_evt  = (state_q == StIdle) && wr_active_q && 32'(wr_off_q) == FRAME_WORDS;
        rd_apply_evt  = (state_q == StIdle) && (rd_pend_q | rd_frame_start) && frame_valid_d;
        rd_repeat_evt = rd_apply_evt && rd_shown_q && (last_full_d == rd_bank_q);
        urgent_evt    = (state_q == StIdle) && wr_elig && rd_elig && rd_urgent_lvl;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_wr_frames_q  <= '0;
            stat_rd_repeats_q <= '0;
            stat_urgent_q     <= '0;
            rd_shown_q        <= 1'b0;
        end else begin
            if (wr_frame_evt && stat_wr_frames_q != 16'hFFFF) begin
                stat_wr_frames_q <= stat_wr_frames_q + 16'd1;
            end
            if (rd_repeat_evt && stat_rd_repeats_q != 16'hFFFF) begin
                stat_rd_repeats_q <= stat_rd_repeats_q + 16'd1;
            end
            if (urgent_evt && stat_urgent_q != 16'hFFFF) begin
                stat_urgent_q <= stat_urgent_q + 16'd1;
            end
            if (rd_apply_evt) rd_shown_q <= 1'b1;
        end
    end

    assign stat_wr_frames  = stat_wr_frames_q;
    assign stat_rd_repeats = stat_rd_repeats_q;
    assign stat_urgent     = stat_urgent_q;
`endif

endmodule

// File: tb/tb_sdram_fb_arbiter.sv
// Directed self-checking bench for sdram_fb_arbiter (FRAME_WORDS = 1000).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_sdram_fb_arbiter;

    localparam int unsigned FW = 1000;

    logic        clk;
    logic        rstn;
    logic        wr_frame_start;
    logic [10:0] wr_fifo_level;
    logic        rd_frame_start;
    logic [10:0] rd_fifo_level;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [23:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic        cmd_done;
    logic [1:0]  wr_bank;
    logic [1:0]  rd_bank;
    logic        frame_valid;

    int checks = 0;
    int errors = 0;

    sdram_fb_arbiter #(
        .BURST_LEN     (256),
        .FRAME_WORDS   (FW),
        .RD_FIFO_DEPTH (1024)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .wr_frame_start (wr_frame_start),
        .wr_fifo_level  (wr_fifo_level),
        .rd_frame_start (rd_frame_start),
        .rd_fifo_level  (rd_fifo_level),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_we         (cmd_we),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_done       (cmd_done),
        .wr_bank        (wr_bank),
        .rd_bank        (rd_bank),
        .frame_valid    (frame_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits (bounded) for a request, records its fields, accepts it and completes it.
    task automatic do_burst(output logic we, output logic [23:0] addr, output logic [8:0] len,
                            output logic ok);
        int n;
        n  = 0;
        ok = 1'b0;
        we = 1'bx; addr = 'x; len = 'x;
        while (cmd_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (cmd_valid === 1'b1) begin
            ok   = 1'b1;
            we   = cmd_we;
            addr = cmd_addr;
            len  = cmd_len;
            cmd_ready = 1'b1;
            @(negedge clk);
            cmd_ready = 1'b0;
            cmd_done  = 1'b1;
            @(negedge clk);
            cmd_done  = 1'b0;
        end
    endtask

    task automatic pulse_wr_start();
        wr_frame_start = 1'b1;
        @(negedge clk);
        wr_frame_start = 1'b0;
    endtask

    task automatic pulse_rd_start();
        rd_frame_start = 1'b1;
        @(negedge clk);
        rd_frame_start = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        int hi;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0 || cmd_we !== 1'b0 || cmd_addr !== 24'h0 || cmd_len !== 9'd0) begin
            errors++;
            $display("FAIL reset_cmd: valid=%b we=%b addr=%h len=%0d want 0 0 000000 0",
                     cmd_valid, cmd_we, cmd_addr, cmd_len);
        end
        checks++;
        if (wr_bank !== 2'd0 || rd_bank !== 2'd0 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_banks: wr_bank=%0d rd_bank=%0d fv=%b want 0 0 0",
                     wr_bank, rd_bank, frame_valid);
        end
        rstn = 1'b1;
        wr_fifo_level = 11'd300;
        @(negedge clk);
        pulse_wr_start();
        n = 0;
        while (cmd_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_prep_req: cmd_valid=%b want 1", cmd_valid);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || cmd_we !== 1'b0 || cmd_addr !== 24'h0 || cmd_len !== 9'd0) begin
            errors++;
            $display("FAIL reset_mid_req: valid=%b we=%b addr=%h len=%0d want 0 0 000000 0",
                     cmd_valid, cmd_we, cmd_addr, cmd_len);
        end
        @(negedge clk);
        rstn = 1'b1;
        // Pending start was cleared, so the writer must stay parked.
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (cmd_valid === 1'b1) hi++;
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL reset_idle_after: cmd_valid high %0d cycles want 0", hi);
        end
    endtask

    task automatic test_write_frame();
        logic [23:0] exp_addr [4];
        logic [8:0]  exp_len [4];
        logic        we, ok;
        logic [23:0] addr;
        logic [8:0]  len;
        int          hi;
        exp_addr[0] = 24'd0;   exp_len[0] = 9'd256;
        exp_addr[1] = 24'd256; exp_len[1] = 9'd256;
        exp_addr[2] = 24'd512; exp_len[2] = 9'd256;
        exp_addr[3] = 24'd768; exp_len[3] = 9'd232;
        wr_fifo_level = 11'd300;
        pulse_wr_start();
        for (int i = 0; i < 4; i++) begin
            do_burst(we, addr, len, ok);
            checks++;
            if (ok !== 1'b1 || we !== 1'b1 || addr !== exp_addr[i] || len !== exp_len[i]) begin
                errors++;
                $display("FAIL write_burst%0d: ok=%b we=%b addr=%h len=%0d want 1 1 %h %0d",
                         i, ok, we, addr, len, exp_addr[i], exp_len[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (frame_valid !== 1'b1 || wr_bank !== 2'd1 || rd_bank !== 2'd0) begin
            errors++;
            $display("FAIL write_complete: fv=%b wr_bank=%0d rd_bank=%0d want 1 1 0",
                     frame_valid, wr_bank, rd_bank);
        end
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (cmd_valid === 1'b1) hi++;
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL writer_parked: cmd_valid high %0d cycles want 0", hi);
        end
    endtask

    task automatic test_read_priority();
        logic        we, ok;
        logic [23:0] addr;
        logic [8:0]  len;
        rd_fifo_level  = 11'd0;
        wr_fifo_level  = 11'd300;
        rd_frame_start = 1'b1;
        wr_frame_start = 1'b1;
        @(negedge clk);
        rd_frame_start = 1'b0;
        wr_frame_start = 1'b0;
        checks++;
        if (rd_bank !== 2'd0 || wr_bank !== 2'd1) begin
            errors++;
            $display("FAIL rd_start_bank: rd_bank=%0d wr_bank=%0d want 0 1", rd_bank, wr_bank);
        end
        do_burst(we, addr, len, ok);
        checks++;
        if (ok !== 1'b1 || we !== 1'b0 || addr !== 24'd0 || len !== 9'd256) begin
            errors++;
            $display("FAIL urgent_read0: ok=%b we=%b addr=%h len=%0d want 1 0 000000 256",
                     ok, we, addr, len);
        end
        // Still urgent: read again even though it also won last time.
        do_burst(we, addr, len, ok);
        checks++;
        if (ok !== 1'b1 || we !== 1'b0 || addr !== 24'd256 || len !== 9'd256) begin
            errors++;
            $display("FAIL urgent_read1: ok=%b we=%b addr=%h len=%0d want 1 0 000100 256",
                     ok, we, addr, len);
        end
    endtask

    task automatic test_alternate();
        logic        exp_we [4];
        logic [23:0] exp_addr [4];
        logic [8:0]  exp_len [4];
        logic        we, ok;
        logic [23:0] addr;
        logic [8:0]  len;
        exp_we[0] = 1'b1; exp_addr[0] = 24'h080000; exp_len[0] = 9'd256;
        exp_we[1] = 1'b0; exp_addr[1] = 24'h000200; exp_len[1] = 9'd256;
        exp_we[2] = 1'b1; exp_addr[2] = 24'h080100; exp_len[2] = 9'd256;
        exp_we[3] = 1'b0; exp_addr[3] = 24'h000300; exp_len[3] = 9'd232;
        rd_fifo_level = 11'd500;
        for (int i = 0; i < 4; i++) begin
            do_burst(we, addr, len, ok);
            checks++;
            if (ok !== 1'b1 || we !== exp_we[i] || addr !== exp_addr[i] || len !== exp_len[i]) begin
                errors++;
                $display("FAIL alternate%0d: ok=%b we=%b addr=%h len=%0d want 1 %b %h %0d",
                         i, ok, we, addr, len, exp_we[i], exp_addr[i], exp_len[i]);
            end
        end
    endtask

    task automatic test_bank_rotate();
        logic        we, ok;
        logic [23:0] addr;
        logic [8:0]  len;
        do_burst(we, addr, len, ok);
        checks++;
        if (ok !== 1'b1 || we !== 1'b1 || addr !== 24'h080200 || len !== 9'd256) begin
            errors++;
            $display("FAIL rotate_w2: ok=%b we=%b addr=%h len=%0d want 1 1 080200 256",
                     ok, we, addr, len);
        end
        do_burst(we, addr, len, ok);
        checks++;
        if (ok !== 1'b1 || we !== 1'b1 || addr !== 24'h080300 || len !== 9'd232) begin
            errors++;
            $display("FAIL rotate_w3: ok=%b we=%b addr=%h len=%0d want 1 1 080300 232",
                     ok, we, addr, len);
        end
        @(negedge clk);
        checks++;
        if (wr_bank !== 2'd2 || rd_bank !== 2'd0 || frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL rotate_wr_bank: wr_bank=%0d rd_bank=%0d fv=%b want 2 0 1",
                     wr_bank, rd_bank, frame_valid);
        end
        pulse_rd_start();
        checks++;
        if (rd_bank !== 2'd1) begin
            errors++;
            $display("FAIL rotate_rd_bank: rd_bank=%0d want 1", rd_bank);
        end
        do_burst(we, addr, len, ok);
        checks++;
        if (ok !== 1'b1 || we !== 1'b0 || addr !== 24'h080000 || len !== 9'd256) begin
            errors++;
            $display("FAIL rotate_read: ok=%b we=%b addr=%h len=%0d want 1 0 080000 256",
                     ok, we, addr, len);
        end
    endtask

    task automatic test_stall();
        int          n;
        logic        we, ok;
        logic [23:0] addr;
        logic [8:0]  len;
        rd_fifo_level = 11'd1000;  // read not eligible: 1000 + 256 > 1024
        pulse_wr_start();
        n = 0;
        while (cmd_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd_we !== 1'b1 || cmd_addr !== 24'h100000 ||
                cmd_len !== 9'd256) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b we=%b addr=%h len=%0d want 1 1 100000 256",
                         i, cmd_valid, cmd_we, cmd_addr, cmd_len);
            end
            cmd_done = (i == 5);  // a done while still in REQ must be ignored
            @(negedge clk);
        end
        cmd_done  = 1'b0;
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drop: cmd_valid=%b want 0", cmd_valid);
        end
        pulse_wr_start();
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_holds: cmd_valid=%b want 0", cmd_valid);
        end
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_gap: cmd_valid=%b want 0", cmd_valid);
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL reissue: cmd_valid=%b want 1", cmd_valid);
        end
        // Restart discarded the partial frame: offset back to 0.
        do_burst(we, addr, len, ok);
        checks++;
        if (ok !== 1'b1 || we !== 1'b1 || addr !== 24'h100000 || len !== 9'd256) begin
            errors++;
            $display("FAIL restart_addr: ok=%b we=%b addr=%h len=%0d want 1 1 100000 256",
                     ok, we, addr, len);
        end
    endtask

    initial begin
        rstn           = 1'b0;
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        wr_fifo_level  = 11'd0;
        rd_fifo_level  = 11'd0;
        cmd_ready      = 1'b0;
        cmd_done       = 1'b0;
        test_reset();
        test_write_frame();
        test_read_priority();
        test_alternate();
        test_bank_rotate();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
